// File: rtl/exa_crosb_pkg.sv
// Shared types, constants and width helper for the crossbar packet demux.
package exa_crosb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DROP  = 2'd2
  } route_state_t;

  localparam int DROP_CNT_W = 16;

  // Number of bits needed to hold the value n (minimum 1), so a select equal to
  // output_num stays expressible and can be recognised as out of range.
  function automatic int log2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((n >> i) != 0) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/exa_skid_buf.sv
// Two-entry valid/ready register slice; in_ready and out_valid come from registers only.
module exa_skid_buf #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [width-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [width-1:0] head_reg;
  logic [width-1:0] spare_reg;
  logic [1:0]       count_reg;
  logic             push;
  logic             pop;

  assign in_ready  = (count_reg != 2'd2);
  assign out_valid = (count_reg != 2'd0);
  assign out_data  = head_reg;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // The head only changes on pop (or on the fill of an empty slice), keeping outputs stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_reg  <= '0;
      spare_reg <= '0;
      count_reg <= 2'd0;
    end else begin
      case (count_reg)
        2'd0: begin
          if (push) begin
            head_reg  <= in_data;
            count_reg <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_reg <= in_data;
          end else if (push) begin
            spare_reg <= in_data;
            count_reg <= 2'd2;
          end else if (pop) begin
            count_reg <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            head_reg  <= spare_reg;
            count_reg <= 2'd1;
          end
        end
        default: count_reg <= 2'd0;
      endcase
    end
  end

endmodule

// File: rtl/exa_crosb_pkt_demux.sv
// Packet-aware 1-to-N crossbar demux: route locked per packet, skid-buffered outputs,
// per-output/per-VC backpressure and a saturating count of dropped packets.
module exa_crosb_pkt_demux
  import exa_crosb_pkg::*;
#(
  parameter int data_width = 128,
  parameter int output_num = 16,
  parameter int vc_num     = 2,
  parameter int sel_width  = log2(output_num),
  parameter int vc_width   = (vc_num > 1) ? log2(vc_num - 1) : 1
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [data_width-1:0]        DATA_i,
  input  logic                         VALID_i,
  input  logic                         LAST_i,
  input  logic [sel_width-1:0]         SEL_i,
  input  logic [vc_width-1:0]          VC_i,
  output logic                         READY_o,
  output logic [data_width-1:0]        DATA_o [output_num],
  output logic [output_num-1:0]        VALID_o,
  output logic [output_num-1:0]        LAST_o,
  output logic [vc_width-1:0]          VC_o,
  input  logic [output_num*vc_num-1:0] READY_i,
  output logic [DROP_CNT_W-1:0]        DROP_CNT_o
);

  localparam int PW = data_width + 1 + sel_width + vc_width;

  route_state_t          state_reg;
  logic [sel_width-1:0]  sel_reg;
  logic [vc_width-1:0]   vc_reg;
  logic [DROP_CNT_W-1:0] drop_cnt_reg;
  logic                  rst_done_reg;

  logic                  accept;
  logic                  routable;
  logic                  stage_push;
  logic                  stage_ready;
  logic [PW-1:0]         stage_in;
  logic [PW-1:0]         head;
  logic                  head_valid;
  logic                  head_ready;
  logic [data_width-1:0] head_data;
  logic                  head_last;
  logic [sel_width-1:0]  head_sel;
  logic [vc_width-1:0]   head_vc;
  logic [output_num*vc_num-1:0] ready_hit;

  // rst_done_reg holds READY_o low through reset; nothing here depends on READY_i.
  assign READY_o    = rst_done_reg & ((state_reg == DROP) | stage_ready);
  assign accept     = VALID_i & READY_o;
  assign routable   = 32'(SEL_i) < 32'(output_num);
  assign stage_push = accept & ((state_reg == ROUTE) | ((state_reg == IDLE) & routable));
  assign stage_in   = (state_reg == IDLE) ? {DATA_i, LAST_i, SEL_i, VC_i}
                                          : {DATA_i, LAST_i, sel_reg, vc_reg};
  assign DROP_CNT_o = drop_cnt_reg;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg    <= IDLE;
      sel_reg      <= '0;
      vc_reg       <= '0;
      drop_cnt_reg <= '0;
      rst_done_reg <= 1'b0;
    end else begin
      rst_done_reg <= 1'b1;
      if (accept) begin
        case (state_reg)
          IDLE: begin
            if (routable) begin
              sel_reg   <= SEL_i;
              vc_reg    <= VC_i;
              state_reg <= LAST_i ? IDLE : ROUTE;
            end else begin
              if (drop_cnt_reg != '1) drop_cnt_reg <= drop_cnt_reg + 1'b1;
              state_reg <= LAST_i ? IDLE : DROP;
            end
          end
          ROUTE, DROP: begin
            if (LAST_i) state_reg <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  exa_skid_buf #(
    .width(PW)
  ) u_skid (
    .clk      (CLK),
    .rst      (RST),
    .in_data  (stage_in),
    .in_valid (stage_push),
    .in_ready (stage_ready),
    .out_data (head),
    .out_valid(head_valid),
    .out_ready(head_ready)
  );

  assign {head_data, head_last, head_sel, head_vc} = head;
  assign VC_o = head_valid ? head_vc : '0;

  genvar gi;
  generate
    for (gi = 0; gi < output_num; gi++) begin : g_out
      assign VALID_o[gi] = head_valid & (head_sel == sel_width'(gi));
      assign LAST_o[gi]  = VALID_o[gi] & head_last;
      assign DATA_o[gi]  = VALID_o[gi] ? head_data : '0;
    end
    for (gi = 0; gi < output_num * vc_num; gi++) begin : g_rdy
      assign ready_hit[gi] = READY_i[gi]
                           & (head_sel == sel_width'(gi / vc_num))
                           & (head_vc == vc_width'(gi % vc_num));
    end
  endgenerate

  assign head_ready = |ready_hit;

endmodule

// File: tb/tb_exa_crosb_pkt_demux.sv
// Scoreboard bench for exa_crosb_pkt_demux: routing, back-to-back, stall, drop, reset, saturation.
module tb_exa_crosb_pkt_demux;

  localparam int DW = 128;
  localparam int ON = 16;
  localparam int VN = 2;
  localparam int SW = 5;
  localparam int VW = 1;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic          valid_i = 1'b0;
  logic          last_i = 1'b0;
  logic [SW-1:0] sel_i = '0;
  logic [VW-1:0] vc_i = '0;
  logic          ready_o;
  logic [DW-1:0] data_o [ON];
  logic [ON-1:0] valid_o;
  logic [ON-1:0] last_o;
  logic [VW-1:0] vc_o;
  logic [ON*VN-1:0] ready_i = '1;
  logic [15:0]   drop_cnt_o;

  typedef struct {
    int            out;
    logic          vc;
    logic          last;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   acc_cnt = 0;

  always #5 CLK = ~CLK;

  exa_crosb_pkt_demux #(
    .data_width(DW),
    .output_num(ON),
    .vc_num    (VN)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .DATA_i    (data_i),
    .VALID_i   (valid_i),
    .LAST_i    (last_i),
    .SEL_i     (sel_i),
    .VC_i      (vc_i),
    .READY_o   (ready_o),
    .DATA_o    (data_o),
    .VALID_o   (valid_o),
    .LAST_o    (last_o),
    .VC_o      (vc_o),
    .READY_i   (ready_i),
    .DROP_CNT_o(drop_cnt_o)
  );

  // Output monitor: checks fan-out cleanliness and pops the scoreboard on each downstream transfer.
  always @(negedge CLK) begin : monitor
    int   o;
    bit   clean;
    exp_t e;
    if (!RST && valid_o != '0) begin
      o = 0;
      clean = $onehot(valid_o) && ((last_o & ~valid_o) == '0);
      for (int i = 0; i < ON; i++) begin
        if (valid_o[i]) o = i;
        else if (data_o[i] != '0) clean = 1'b0;
      end
      total_cnt++;
      if (clean) pass_cnt++;
      else $display("FAIL fanout valid=%h last=%h (expected one-hot valid, zero elsewhere)", valid_o, last_o);
      if (ready_i[o*VN + int'(vc_o)]) begin
        total_cnt++;
        if (sb.size() == 0) begin
          $display("FAIL beat unexpected beat on out=%0d data=%h, expected none", o, data_o[o]);
        end else begin
          e = sb.pop_front();
          if (o == e.out && vc_o === e.vc && last_o[o] === e.last && data_o[o] === e.data) begin
            pass_cnt++;
            $display("beat out=%0d vc=%0d last=%0b data=%h", o, vc_o, last_o[o], data_o[o]);
          end else begin
            $display("FAIL beat got out=%0d vc=%0d last=%0b data=%h expected out=%0d vc=%0d last=%0b data=%h",
                     o, vc_o, last_o[o], data_o[o], e.out, e.vc, e.last, e.data);
          end
        end
      end
    end
  end

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Presents one beat, holds it until accepted, and returns #1 after the accepting edge.
  task automatic drive_beat(input logic [DW-1:0] d, input logic last, input logic [SW-1:0] sel,
                            input logic vc, input bit routed, input int out_idx,
                            input logic exp_vc, output int waits);
    bit   done;
    exp_t e;
    done  = 1'b0;
    waits = 0;
    data_i = d; last_i = last; sel_i = sel; vc_i = vc; valid_i = 1'b1;
    while (!done && waits < 50) begin
      @(negedge CLK);
      if (ready_o) begin
        done = 1'b1;
        acc_cnt++;
        if (routed) begin
          e.out = out_idx; e.vc = exp_vc; e.last = last; e.data = d;
          sb.push_back(e);
        end
      end
      @(posedge CLK); #1;
      if (!done) waits++;
    end
    valid_i = 1'b0;
    if (!done) begin
      total_cnt++;
      $display("FAIL accept_timeout beat not accepted after %0d cycles, expected acceptance", waits);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge CLK); #1;
      n++;
    end
    total_cnt++;
    if (sb.size() == 0) pass_cnt++;
    else $display("FAIL drain %0d beats left, expected 0", sb.size());
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    bit zero;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    zero = 1'b1;
    for (int i = 0; i < ON; i++) if (data_o[i] !== '0) zero = 1'b0;
    total_cnt += 6;
    if (ready_o !== 1'b0) $display("FAIL rst_ready got %b expected 0", ready_o); else pass_cnt++;
    if (valid_o !== '0) $display("FAIL rst_valid got %h expected 0", valid_o); else pass_cnt++;
    if (last_o !== '0) $display("FAIL rst_last got %h expected 0", last_o); else pass_cnt++;
    if (vc_o !== '0) $display("FAIL rst_vc got %h expected 0", vc_o); else pass_cnt++;
    if (drop_cnt_o !== 16'h0) $display("FAIL rst_dropcnt got %h expected 0", drop_cnt_o); else pass_cnt++;
    if (!zero) $display("FAIL rst_data got nonzero expected all 0"); else pass_cnt++;
    RST = 1'b0;
    @(posedge CLK); #1;
    total_cnt++;
    if (ready_o !== 1'b1) $display("FAIL rst_release_ready got %b expected 1", ready_o); else pass_cnt++;
  endtask

  task automatic test_route();
    int w;
    logic [SW-1:0] sels [4];
    sels[0] = 5'd5; sels[1] = 5'd9; sels[2] = 5'd16; sels[3] = 5'd0;
    ready_i = '1;
    for (int b = 0; b < 4; b++) begin
      drive_beat(rnd_data(), (b == 3), sels[b], (b == 0), 1'b1, 5, 1'b1, w);
      total_cnt++;
      if (valid_o !== 16'h0020 || vc_o !== 1'b1)
        $display("FAIL route_b%0d valid=%h vc=%0d expected valid=0020 vc=1", b, valid_o, vc_o);
      else pass_cnt++;
    end
    total_cnt++;
    if (last_o !== 16'h0020) $display("FAIL route_last got %h expected 0020", last_o); else pass_cnt++;
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int w;
    int outs [3];
    outs[0] = 3; outs[1] = 7; outs[2] = 3;
    for (int k = 0; k < 3; k++) begin
      drive_beat(rnd_data(), 1'b1, SW'(outs[k]), k[0], 1'b1, outs[k], k[0], w);
      total_cnt++;
      if (valid_o !== (16'(1) << outs[k]) || last_o !== (16'(1) << outs[k]) || w != 0)
        $display("FAIL b2b_%0d valid=%h last=%h waits=%0d expected valid=last=%h waits=0",
                 k, valid_o, last_o, w, 16'(1) << outs[k]);
      else pass_cnt++;
    end
    wait_drain();
  endtask

  task automatic test_backpressure();
    int w;
    acc_cnt = 0;
    ready_i = '1;
    ready_i[4] = 1'b0;
    fork
      begin
        for (int b = 0; b < 4; b++)
          drive_beat(rnd_data(), (b == 3), (b == 0) ? 5'd2 : 5'd11, 1'b0, 1'b1, 2, 1'b0, w);
      end
      begin
        repeat (5) @(posedge CLK);
        #1;
        total_cnt++;
        if (acc_cnt != 2 || ready_o !== 1'b0 || valid_o !== 16'h0004)
          $display("FAIL stall accepted=%0d ready=%b valid=%h expected accepted=2 ready=0 valid=0004",
                   acc_cnt, ready_o, valid_o);
        else pass_cnt++;
        ready_i = '1;
      end
    join
    wait_drain();
  endtask

  task automatic test_drop();
    int w;
    total_cnt++;
    if (drop_cnt_o !== 16'd0) $display("FAIL drop_pre got %0d expected 0", drop_cnt_o); else pass_cnt++;
    for (int b = 0; b < 3; b++) begin
      drive_beat(rnd_data(), (b == 2), 5'd16, 1'b0, 1'b0, 0, 1'b0, w);
      total_cnt++;
      if (w != 0 || valid_o !== '0)
        $display("FAIL drop_b%0d waits=%0d valid=%h expected waits=0 valid=0", b, w, valid_o);
      else pass_cnt++;
    end
    total_cnt++;
    if (drop_cnt_o !== 16'd1) $display("FAIL drop_cnt got %0d expected 1", drop_cnt_o); else pass_cnt++;
    for (int b = 0; b < 2; b++) begin
      drive_beat(rnd_data(), (b == 1), 5'd1, 1'b1, 1'b1, 1, 1'b1, w);
      total_cnt++;
      if (valid_o !== 16'h0002) $display("FAIL drop_next got valid=%h expected 0002", valid_o); else pass_cnt++;
    end
    wait_drain();
  endtask

  task automatic test_reset_mid_packet();
    int w;
    drive_beat(rnd_data(), 1'b0, 5'd6, 1'b0, 1'b1, 6, 1'b0, w);
    data_i = rnd_data(); last_i = 1'b0; sel_i = 5'd6;
    RST = 1'b1;
    #1;
    sb.delete();
    total_cnt++;
    if (valid_o !== '0 || last_o !== '0 || ready_o !== 1'b0 || data_o[6] !== '0)
      $display("FAIL mid_rst valid=%h last=%h ready=%b expected all 0", valid_o, last_o, ready_o);
    else pass_cnt++;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    total_cnt++;
    if (ready_o !== 1'b1 || drop_cnt_o !== 16'd0)
      $display("FAIL mid_rst_release ready=%b dropcnt=%0d expected ready=1 dropcnt=0", ready_o, drop_cnt_o);
    else pass_cnt++;
    for (int b = 0; b < 3; b++) begin
      drive_beat(rnd_data(), (b == 2), (b == 0) ? 5'd9 : 5'd4, 1'b0, 1'b1, 9, 1'b0, w);
      total_cnt++;
      if (valid_o !== 16'h0200) $display("FAIL mid_rst_route got valid=%h expected 0200", valid_o); else pass_cnt++;
    end
    wait_drain();
  endtask

  task automatic test_saturate();
    int  acc;
    bit  near_done;
    acc = 0;
    near_done = 1'b0;
    data_i = '0; last_i = 1'b1; sel_i = 5'd16; vc_i = 1'b0; valid_i = 1'b1;
    for (int c = 0; c < 66000 && acc < 65540; c++) begin
      @(negedge CLK);
      if (ready_o) acc++;
      @(posedge CLK); #1;
      if (acc == 65534 && !near_done) begin
        near_done = 1'b1;
        total_cnt++;
        if (drop_cnt_o !== 16'hFFFE) $display("FAIL sat_near got %h expected fffe", drop_cnt_o); else pass_cnt++;
      end
    end
    valid_i = 1'b0;
    last_i = 1'b0;
    total_cnt++;
    if (drop_cnt_o !== 16'hFFFF || acc != 65540)
      $display("FAIL sat_hold got %h after %0d packets expected ffff after 65540", drop_cnt_o, acc);
    else pass_cnt++;
    @(posedge CLK); #1;
  endtask

  initial begin
    #1;
    test_reset();
    test_route();
    test_back_to_back();
    test_backpressure();
    test_drop();
    test_reset_mid_packet();
    test_saturate();
    total_cnt++;
    if (sb.size() != 0) $display("FAIL sb_final %0d beats outstanding expected 0", sb.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/exa_crosb_pkt_demux.md
# exa_crosb_pkt_demux

Packet-aware, registered 1-to-N crossbar demultiplexer with virtual-channel (VC) routing and per-output/per-VC backpressure. It sits between an input port's buffer and the crossbar column muxes. It latches the route (output, VC) on the first beat of each packet and holds it until `LAST`. A two-entry skid stage gives registered outputs at full throughput, and packets addressed to a non-existent output are dropped and counted.

## Interface
- `data_width`, 128, payload width per beat
- `output_num`, 16, number of crossbar outputs
- `vc_num`, 2, virtual channels per output
- `sel_width`, `log2(output_num)`, width of output select
- `vc_width`, `log2(vc_num)` (min 1), width of VC select
- `CLK`  in  1  clock; all logic is on the rising edge
- `RST`  in  1  asynchronous, active-high reset
- `DATA_i`  in  data_width  upstream beat
- `VALID_i`  in  1  upstream beat valid
- `LAST_i`  in  1  final beat of packet
- `SEL_i`  in  sel_width  destination output, sampled on first beat only
- `VC_i`  in  vc_width  destination VC, sampled on first beat only
- `READY_o`  out  1  upstream may transfer when `VALID_i & READY_o`
- `DATA_o[output_num]`  out  data_width each  per-output beat; zero when that output is not valid
- `VALID_o`  out  output_num  one-hot or zero
- `LAST_o`  out  output_num  `LAST` on the valid output, else 0
- `VC_o`  out  vc_width  VC of the current output beat
- `READY_i`  in  output_num*vc_num  downstream ready, index `out*vc_num+vc`
- `DROP_CNT_o`  out  16  saturating count of dropped packets

## Operation
- Route FSM states:
  - `IDLE`: awaiting a first beat.
  - `ROUTE`: a packet is locked to (`sel_q`, `vc_q`).
  - `DROP`: a packet is being sunk.
- `IDLE` with an accepted beat:
  - If `SEL_i < output_num`, latch `SEL_i`/`VC_i`, push the beat, and go to `ROUTE`.
  - Otherwise go to `DROP`, discard the beat, and increment `DROP_CNT_o`.
  - In either case, if `LAST_i` is set, stay in `IDLE` (single-beat packet).
- `ROUTE`: every accepted beat is pushed with the latched route; `SEL_i`/`VC_i` are ignored. Accepted `LAST_i` returns the FSM to `IDLE`.
- `DROP`: `READY_o` is 1 and beats are discarded. Accepted `LAST_i` returns the FSM to `IDLE`.
- The skid stage (2 entries) stores {data, last, sel, vc}. Its head drives the output of index `sel`. It pops when `READY_i[sel*vc_num+vc]` is 1.
- `READY_o` = stage not full (registered, no combinational path from `READY_i`). In `DROP`, `READY_o` = 1 regardless of the stage.
- `DROP_CNT_o` saturates at 16'hFFFF. It counts packets, not beats.

## Timing
- Latency: beat accepted at edge *n* appears on `VALID_o` after edge *n*, i.e. 1 cycle.
- Throughput: 1 beat/cycle while the destination ready stays high.
- Downstream stall: at most one further beat is accepted into the second entry, then `READY_o` drops in the next cycle.
- Ready release: after the destination ready returns, `READY_o` rises one cycle after the stage has a free entry.
- `VALID_o` deasserted with data held stable is not allowed: once asserted, `VALID_o`/`DATA_o`/`LAST_o`/`VC_o` hold until popped.
- Back-to-back packets: the first beat of packet *k+1* may be accepted in the cycle after `LAST` of packet *k*, and may target a different output; ordering is preserved through the stage.
- Reset values:
  - FSM in `IDLE`, stage empty.
  - `VALID_o`=0, `LAST_o`=0, all `DATA_o`=0, `VC_o`=0.
  - `READY_o`=0 during `RST`, and 1 in the first cycle after release.
  - `DROP_CNT_o`=0.
- Reset mid-packet: the partial packet is discarded with no `LAST` emitted, and the next beat after release is treated as a first beat.

## Structure
- Package `exa_crosb_pkg` holds:
  - the `route_state_t` enum (`IDLE`, `ROUTE`, `DROP`),
  - the `DROP_CNT_W`=16 constant,
  - the `log2` helper from `ceiling_up_log2.vh`.
- Sub-module `exa_skid_buf`: 2-entry valid/ready register slice parametrised on payload width. It is instantiated once with payload = data_width+1+sel_width+vc_width.
- The output fan-out (zeroing non-selected outputs) is combinational from the skid head.

## Test plan
- 4-beat packet, `SEL_i`=5, `VC_i`=1, all ready, `SEL_i` changed on beats 2–4 → beats on `VALID_o[5]` only, `VC_o`=1, `LAST_o[5]` on beat 4, 1-cycle latency.
- Single-beat packets to outputs 3, 7, 3 back-to-back → three consecutive cycles of valid on 3, 7, 3, with `LAST` on each and `READY_o` continuously 1.
- Packet to output 2/VC 0 with `READY_i[4]`=0 for 5 cycles → 2 beats buffered, `READY_o`=0 in the next cycle, no data loss. On release, beats drain in order.
- `SEL_i`=16 with `output_num`=16, 3 beats → no `VALID_o`, `READY_o`=1 throughout, `DROP_CNT_o` 0→1. The next packet routes normally.
- `RST` asserted on beat 2 of a 4-beat packet → all outputs 0 immediately. After release, a new packet to output 9 routes to 9.
- Preload `DROP_CNT_o` near max via 65536 dropped packets (or force) → value holds at 16'hFFFF.
